// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : risc_pkg
//  Description : Shared definitions for the 16-bit RISC pipeline: opcode
//                constants, fetch FSM state type, the injected interrupt
//                instruction word and the two-word opcode classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

    localparam logic [4:0] OP_LDM  = 5'b00111;
    localparam logic [4:0] OP_LDD  = 5'b01110;
    localparam logic [4:0] OP_STD  = 5'b01111;
    localparam logic [4:0] OP_CALL = 5'b11110;

    // Interrupt entry is a CALL with an all-zero operand field
    localparam logic [15:0] INT_INSTR = {OP_CALL, 11'b0};

    typedef enum logic [0:0] {
        FETCH     = 1'b0,
        FETCH_IMM = 1'b1
    } fetch_state_t;

    // Opcodes followed by an immediate / effective-address word
    function automatic logic is_two_word(input logic [4:0] opcode);
        return (opcode == OP_LDM) || (opcode == OP_LDD) || (opcode == OP_STD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_register.sv
`default_nettype none
// ============================================================================
//  Module      : pc_register
//  Description : Program counter register. Priority: reset > load > hold >
//                increment. Increment wraps modulo 2^PC_W.
//  Ports       : clk, rst_n (sync, active-low)
//                load / load_pc : redirect target load
//                hold           : keep current value
//                inc            : advance by one word
//                pc             : current program counter
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_register #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [PC_W-1:0] load_pc,
    input  logic            hold,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (load) begin
            r_pc <= load_pc;
        end else if (!hold && inc) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Drives the instruction memory from
//                the PC, assembles two-word instructions (LDM/LDD/STD) and
//                presents one complete instruction per valid cycle in the
//                registered IF/ID outputs.
//  Ports       : clk, rst_n (sync, active-low)
//                imem_addr/imem_rdata : async-read instruction memory
//                stall                : freeze PC, state and IF/ID
//                redirect_valid/pc    : taken control transfer
//                if_valid/instr/imm/pc/next_pc : IF/ID register
//                int_req, if_int      : interrupt injection (FETCH_INT_EN)
//  Config      : `define FETCH_INT_EN adds the interrupt injection logic
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import risc_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_valid,
    output logic [15:0]     if_instr,
    output logic [15:0]     if_imm,
    output logic [PC_W-1:0] if_pc,
    output logic [PC_W-1:0] if_next_pc
`ifdef FETCH_INT_EN
    ,
    input  logic            int_req,
    output logic            if_int
`endif
);

    fetch_state_t    r_state, w_state_nxt;
    logic [15:0]     r_hold, w_hold_nxt;
    logic [PC_W-1:0] r_hold_pc, w_hold_pc_nxt;
    logic            w_valid_nxt;
    logic [15:0]     w_instr_nxt, w_imm_nxt;
    logic [PC_W-1:0] w_if_pc_nxt, w_if_next_pc_nxt;
    logic [PC_W-1:0] w_pc, w_pc_plus1;
    logic            w_int_take;

    pc_register #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .hold    (stall),
        .inc     (!w_int_take),
        .pc      (w_pc)
    );

    assign imem_addr  = w_pc;
    assign w_pc_plus1 = w_pc + 1'b1;

`ifdef FETCH_INT_EN
    logic r_int_pend;
    logic w_int_pend;

    // A request is serviceable in the same cycle it arrives; otherwise it
    // waits in r_int_pend until the FSM is back in FETCH without stall/redirect.
    assign w_int_pend = r_int_pend | int_req;
    assign w_int_take = w_int_pend && (r_state == FETCH) && !redirect_valid && !stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_int_pend <= 1'b0;
            if_int     <= 1'b0;
        end else begin
            r_int_pend <= w_int_pend && !w_int_take;
            if (redirect_valid) begin
                if_int <= 1'b0;
            end else if (!stall) begin
                if_int <= w_int_take;
            end
        end
    end
`else
    assign w_int_take = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_hold_nxt       = r_hold;
        w_hold_pc_nxt    = r_hold_pc;
        w_valid_nxt      = if_valid;
        w_instr_nxt      = if_instr;
        w_imm_nxt        = if_imm;
        w_if_pc_nxt      = if_pc;
        w_if_next_pc_nxt = if_next_pc;

        if (redirect_valid) begin
            // Any half-assembled instruction is dropped here
            w_state_nxt = FETCH;
            w_valid_nxt = 1'b0;
        end else if (!stall) begin
            unique case (r_state)
                FETCH: begin
                    if (w_int_take) begin
                        // Return address is the un-fetched PC itself
                        w_instr_nxt      = INT_INSTR;
                        w_imm_nxt        = '0;
                        w_if_pc_nxt      = w_pc;
                        w_if_next_pc_nxt = w_pc;
                        w_valid_nxt      = 1'b1;
                    end else if (is_two_word(imem_rdata[15:11])) begin
                        w_hold_nxt    = imem_rdata;
                        w_hold_pc_nxt = w_pc;
                        w_valid_nxt   = 1'b0;
                        w_state_nxt   = FETCH_IMM;
                    end else begin
                        w_instr_nxt      = imem_rdata;
                        w_imm_nxt        = '0;
                        w_if_pc_nxt      = w_pc;
                        w_if_next_pc_nxt = w_pc_plus1;
                        w_valid_nxt      = 1'b1;
                    end
                end
                FETCH_IMM: begin
                    w_instr_nxt      = r_hold;
                    w_imm_nxt        = imem_rdata;
                    w_if_pc_nxt      = r_hold_pc;
                    w_if_next_pc_nxt = w_pc_plus1;
                    w_valid_nxt      = 1'b1;
                    w_state_nxt      = FETCH;
                end
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= FETCH;
            r_hold     <= '0;
            r_hold_pc  <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_imm     <= '0;
            if_pc      <= '0;
            if_next_pc <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_hold_pc  <= w_hold_pc_nxt;
            if_valid   <= w_valid_nxt;
            if_instr   <= w_instr_nxt;
            if_imm     <= w_imm_nxt;
            if_pc      <= w_if_pc_nxt;
            if_next_pc <= w_if_next_pc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: directed reset/stall/
//                redirect/wrap sequences, a table of single instructions and
//                a randomized run against an instruction-stream model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int          PC_W     = 16;
    localparam logic [15:0] RST_PC   = 16'h0010;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic            stall;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            if_valid;
    logic [15:0]     if_instr;
    logic [15:0]     if_imm;
    logic [PC_W-1:0] if_pc;
    logic [PC_W-1:0] if_next_pc;
`ifdef FETCH_INT_EN
    logic            int_req;
    logic            if_int;
`endif

    logic [15:0] mem [0:65535];
    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_imm         (if_imm),
        .if_pc          (if_pc),
        .if_next_pc     (if_next_pc)
`ifdef FETCH_INT_EN
        ,
        .int_req        (int_req),
        .if_int         (if_int)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [15:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        step();
        redirect_valid = 1'b0;
    endtask

    // Instruction-level view of memory: what the instruction at address a is
    function automatic logic two_word_op(input logic [15:0] w);
        logic [4:0] op;
        op = w[15:11];
        return (op == 5'd7) || (op == 5'd14) || (op == 5'd15);
    endfunction

    typedef struct {
        logic [15:0] addr;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] e_instr;
        logic [15:0] e_imm;
        logic [15:0] e_next;
        int          lat;
    } vec_t;

    vec_t tbl [8];

    // random-phase model state
    logic [15:0] m_p;
    logic        m_half;

    initial begin
        logic [15:0] w, a, nxt, ea;
        logic        two, st, rd;
        logic [15:0] p_instr, p_imm, p_pc, p_npc;
        logic        p_valid;

        tbl[0] = '{16'h0030, 16'h0800, 16'h0000, 16'h0800, 16'h0000, 16'h0031, 1};
        tbl[1] = '{16'h0020, 16'h3800, 16'hBEEF, 16'h3800, 16'hBEEF, 16'h0022, 2};
        tbl[2] = '{16'hFFFF, 16'h7000, 16'h0005, 16'h7000, 16'h0005, 16'h0001, 2};
        tbl[3] = '{16'hFFFF, 16'h3000, 16'h0000, 16'h3000, 16'h0000, 16'h0000, 1};
        tbl[4] = '{16'h0410, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 16'h0411, 1};
        tbl[5] = '{16'h0420, 16'h7800, 16'h1234, 16'h7800, 16'h1234, 16'h0422, 2};
        tbl[6] = '{16'h0430, 16'h6800, 16'h0000, 16'h6800, 16'h0000, 16'h0431, 1};
        tbl[7] = '{16'h0440, 16'hF000, 16'h0000, 16'hF000, 16'h0000, 16'h0441, 1};

        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[15:11] = 5'd14 + 5'($urandom_range(0, 1));
            mem[i] = w;
        end

        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
`ifdef FETCH_INT_EN
        int_req = 1'b0;
`endif
        // ---------------- reset ----------------
        mem[16'h0010] = 16'h0800;
        mem[16'h0011] = 16'h1000;
        step(); step(); step();
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_instr", {16'b0, if_instr}, 32'd0);
        chk("rst_imm",   {16'b0, if_imm}, 32'd0);
        chk("rst_pc",    {16'b0, if_pc}, 32'd0);
        chk("rst_npc",   {16'b0, if_next_pc}, 32'd0);
        chk("rst_addr",  {16'b0, imem_addr}, 32'h0010);
        rst_n = 1'b1;
        step();
        chk("boot_valid", {31'b0, if_valid}, 32'd1);
        chk("boot_instr", {16'b0, if_instr}, 32'h0800);
        chk("boot_pc",    {16'b0, if_pc}, 32'h0010);
        chk("boot_npc",   {16'b0, if_next_pc}, 32'h0011);
        step();
        chk("boot2_instr", {16'b0, if_instr}, 32'h1000);

        // ---------------- table of single instructions ----------------
        for (int i = 0; i < 8; i++) begin
            mem[tbl[i].addr]         = tbl[i].w0;
            mem[tbl[i].addr + 16'd1] = tbl[i].w1;
            redirect_to(tbl[i].addr);
            chk("tbl_redir_bubble", {31'b0, if_valid}, 32'd0);
            step();
            if (tbl[i].lat == 2) begin
                chk("tbl_imm_bubble", {31'b0, if_valid}, 32'd0);
                step();
            end
            chk("tbl_valid", {31'b0, if_valid}, 32'd1);
            chk("tbl_instr", {16'b0, if_instr}, {16'b0, tbl[i].e_instr});
            chk("tbl_imm",   {16'b0, if_imm}, {16'b0, tbl[i].e_imm});
            chk("tbl_pc",    {16'b0, if_pc}, {16'b0, tbl[i].addr});
            chk("tbl_npc",   {16'b0, if_next_pc}, {16'b0, tbl[i].e_next});
        end

        // ---------------- stall during FETCH_IMM of STD ----------------
        mem[16'h0050] = 16'h7800; mem[16'h0051] = 16'h1234; mem[16'h0052] = 16'h0800;
        redirect_to(16'h0050);
        step();                                   // opcode word captured
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stl_valid", {31'b0, if_valid}, 32'd0);
            chk("stl_addr",  {16'b0, imem_addr}, 32'h0051);
        end
        stall = 1'b0;
        step();
        chk("stl_out_valid", {31'b0, if_valid}, 32'd1);
        chk("stl_out_instr", {16'b0, if_instr}, 32'h7800);
        chk("stl_out_imm",   {16'b0, if_imm}, 32'h1234);
        chk("stl_out_pc",    {16'b0, if_pc}, 32'h0050);
        chk("stl_out_npc",   {16'b0, if_next_pc}, 32'h0052);
        step();
        chk("stl_once_instr", {16'b0, if_instr}, 32'h0800);
        chk("stl_once_imm",   {16'b0, if_imm}, 32'h0000);

        // ---------------- redirect while stalled in FETCH_IMM ----------------
        mem[16'h0060] = 16'h3800; mem[16'h0061] = 16'hAAAA; mem[16'h0100] = 16'h1000;
        redirect_to(16'h0060);
        step();
        stall = 1'b1;
        redirect_to(16'h0100);
        chk("rds_bubble", {31'b0, if_valid}, 32'd0);
        stall = 1'b0;
        step();
        chk("rds_valid", {31'b0, if_valid}, 32'd1);
        chk("rds_pc",    {16'b0, if_pc}, 32'h0100);
        chk("rds_instr", {16'b0, if_instr}, 32'h1000);
        chk("rds_imm",   {16'b0, if_imm}, 32'h0000);

`ifdef FETCH_INT_EN
        // ---------------- interrupt injection ----------------
        mem[16'h0040] = 16'h0800;
        redirect_to(16'h0040);
        int_req = 1'b1;
        step();
        int_req = 1'b0;
        chk("int_instr", {16'b0, if_instr}, 32'hF000);
        chk("int_flag",  {31'b0, if_int}, 32'd1);
        chk("int_pc",    {16'b0, if_pc}, 32'h0040);
        chk("int_npc",   {16'b0, if_next_pc}, 32'h0040);
        step();
        chk("int_resume_pc", {16'b0, if_pc}, 32'h0040);
        chk("int_resume_instr", {16'b0, if_instr}, 32'h0800);
        chk("int_resume_flag", {31'b0, if_int}, 32'd0);
        // request arriving mid two-word instruction waits for it
        mem[16'h0070] = 16'h3800; mem[16'h0071] = 16'h5555;
        redirect_to(16'h0070);
        step();
        int_req = 1'b1;
        step();
        int_req = 1'b0;
        chk("int_nosplit_instr", {16'b0, if_instr}, 32'h3800);
        chk("int_nosplit_flag",  {31'b0, if_int}, 32'd0);
        step();
        chk("int_after_instr", {16'b0, if_instr}, 32'hF000);
        chk("int_after_pc",    {16'b0, if_pc}, 32'h0072);
        // redirect wins, request stays pending
        int_req = 1'b1;
        redirect_to(16'h0040);
        int_req = 1'b0;
        chk("int_redir_bubble", {31'b0, if_valid}, 32'd0);
        step();
        chk("int_redir_instr", {16'b0, if_instr}, 32'hF000);
        chk("int_redir_pc",    {16'b0, if_pc}, 32'h0040);
`endif

        // ---------------- randomized run vs instruction-stream model ----------------
        for (int c = 0; c < 600; c++) begin
            st = ($urandom_range(0, 3) == 0);
            rd = (c == 0) || ($urandom_range(0, 15) == 0);
            a  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = 16'hFFFE + 16'($urandom_range(0, 1));
            p_valid = if_valid; p_instr = if_instr; p_imm = if_imm;
            p_pc = if_pc; p_npc = if_next_pc;
            stall = st; redirect_valid = rd; redirect_pc = a;
            step();
            if (rd) begin
                m_p = a; m_half = 1'b0;
                chk("rnd_redir_valid", {31'b0, if_valid}, 32'd0);
            end else if (st) begin
                chk("rnd_stall_hold", {if_valid, if_instr, if_pc[14:0]},
                    {p_valid, p_instr, p_pc[14:0]});
                chk("rnd_stall_hold2", {if_imm, if_next_pc}, {p_imm, p_npc});
            end else begin
                two = two_word_op(mem[m_p]);
                if (two && !m_half) begin
                    m_half = 1'b1;
                    chk("rnd_bubble", {31'b0, if_valid}, 32'd0);
                end else begin
                    ea  = two ? mem[16'(m_p + 16'd1)] : 16'h0000;
                    nxt = m_p + (two ? 16'd2 : 16'd1);
                    chk("rnd_valid", {31'b0, if_valid}, 32'd1);
                    chk("rnd_instr_imm", {if_instr, if_imm}, {mem[m_p], ea});
                    chk("rnd_pc_npc", {if_pc, if_next_pc}, {m_p, nxt});
                    m_p = nxt; m_half = 1'b0;
                end
            end
            chk("rnd_addr", {16'b0, imem_addr}, {16'b0, m_half ? 16'(m_p + 16'd1) : m_p});
        end
        stall = 1'b0; redirect_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
